// File: rtl/ram_port_arbiter_if.sv
// Requester-side bundle for the shared RAM port arbiter.
// master = requesters, slave = arbiter.
interface ram_port_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_REQ    = 2
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            req_we;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_din;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            rvalid;
    logic [DATA_WIDTH-1:0]         rdata;

    modport master (
        output req, req_we, req_addr, req_din,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, req_we, req_addr, req_din,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM
// among NUM_REQ requesters, with per-requester read strobes.
module ram_port_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_REQ    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    ram_port_arbiter_if.slave     rq,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);
    localparam int IW = $clog2(NUM_REQ);

    logic [IW-1:0] prio_q, prio_d;
    logic          rd_pend_q, rd_pend_d;
    logic [IW-1:0] rd_id_q, rd_id_d;

    logic          found;
    logic [IW-1:0] win;

    // Scan from prio upward with wrap-around; first asserted request wins.
    always_comb begin
        logic [IW:0] idx;
        found = 1'b0;
        win   = '0;
        idx   = '0;
        if (!rst) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = {1'b0, prio_q} + (IW+1)'(k);
                if (idx >= (IW+1)'(NUM_REQ)) begin
                    idx = idx - (IW+1)'(NUM_REQ);
                end
                if (!found && rq.req[idx[IW-1:0]]) begin
                    found = 1'b1;
                    win   = idx[IW-1:0];
                end
            end
        end
    end

    always_comb begin
        rq.gnt   = '0;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (found && win == IW'(i)) begin
                rq.gnt[i] = 1'b1;
                ram_we    = rq.req_we[i];
                ram_addr  = rq.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                ram_din   = rq.req_din[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        prio_d    = prio_q;
        rd_pend_d = 1'b0;
        rd_id_d   = rd_id_q;
        if (found) begin
            prio_d    = (win == IW'(NUM_REQ-1)) ? '0 : win + 1'b1;
            rd_pend_d = !rq.req_we[win];
            rd_id_d   = win;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q    <= '0;
            rd_pend_q <= 1'b0;
            rd_id_q   <= '0;
        end else begin
            prio_q    <= prio_d;
            rd_pend_q <= rd_pend_d;
            rd_id_q   <= rd_id_d;
        end
    end

    // Response of a read granted just before reset is dropped.
    always_comb begin
        rq.rvalid = '0;
        rq.rdata  = '0;
        if (!rst && rd_pend_q) begin
            rq.rdata = ram_dout;
            for (int i = 0; i < NUM_REQ; i++) begin
                rq.rvalid[i] = (rd_id_q == IW'(i));
            end
        end
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed scenarios plus random traffic
// against a transaction-level model with its own memory image.
module tb_ram_port_arbiter;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int NR = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    always #5 clk = ~clk;

    ram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR)) bus();

    ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR)) dut (
        .clk      (clk),
        .rst      (rst),
        .rq       (bus),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    logic [DW-1:0] mem [2**AW];

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        else        ram_dout      <= mem[ram_addr];
    end

    logic [DW-1:0] ref_mem [2**AW];
    int            m_prio;
    bit            m_pend;
    int            m_id;
    logic [DW-1:0] m_data;
    int            exp_win;
    logic [NR-1:0] obs_gnt;
    int            n_cmp;
    int            n_err;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input bit r, input bit we,
                           input int a, input int d);
        bus.req[i]                = r;
        bus.req_we[i]             = we;
        bus.req_addr[i*AW +: AW]  = AW'(a);
        bus.req_din[i*DW +: DW]   = DW'(d);
    endtask

    // One clock: check at negedge, advance the model at the edge,
    // then retire the granted request.
    task automatic cycle();
        logic [NR-1:0] eg;
        logic          ewe;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic [NR-1:0] erv;
        logic [DW-1:0] erd;
        @(negedge clk);
        exp_win = -1;
        eg  = '0;
        ewe = 1'b0;
        ea  = '0;
        ed  = '0;
        if (!rst) begin
            for (int k = 0; k < NR; k++) begin
                int j;
                j = (m_prio + k) % NR;
                if (exp_win < 0 && bus.req[j]) exp_win = j;
            end
        end
        if (exp_win >= 0) begin
            eg[exp_win] = 1'b1;
            ewe = bus.req_we[exp_win];
            ea  = bus.req_addr[exp_win*AW +: AW];
            ed  = bus.req_din[exp_win*DW +: DW];
        end
        erv = '0;
        erd = '0;
        if (!rst && m_pend) begin
            erv[m_id] = 1'b1;
            erd = m_data;
        end
        chk("gnt",      32'(bus.gnt),    32'(eg));
        chk("ram_we",   32'(ram_we),     32'(ewe));
        chk("ram_addr", 32'(ram_addr),   32'(ea));
        chk("ram_din",  32'(ram_din),    32'(ed));
        chk("rvalid",   32'(bus.rvalid), 32'(erv));
        chk("rdata",    32'(bus.rdata),  32'(erd));
        obs_gnt = bus.gnt;
        @(posedge clk);
        if (rst) begin
            m_prio = 0;
            m_pend = 0;
        end else if (exp_win >= 0) begin
            if (ewe) begin
                ref_mem[ea] = ed;
                m_pend = 0;
            end else begin
                m_pend = 1;
                m_id   = exp_win;
                m_data = ref_mem[ea];
            end
            m_prio = (exp_win + 1) % NR;
        end else begin
            m_pend = 0;
        end
        #1;
        if (exp_win >= 0) bus.req[exp_win] = 1'b0;
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        m_prio = 0;
        m_pend = 0;
        m_id   = 0;
        m_data = '0;
        ram_dout = '0;
        for (int a = 0; a < 2**AW; a++) begin
            mem[a]     = '0;
            ref_mem[a] = '0;
        end
        bus.req = '0; bus.req_we = '0; bus.req_addr = '0; bus.req_din = '0;

        // reset with both requesting
        rst = 1'b1;
        set_req(0, 1, 0, 0, 0);
        set_req(1, 1, 0, 0, 0);
        cycle();
        cycle();
        chk("rst_rvalid", 32'(bus.rvalid), 32'h0);
        chk("rst_rdata",  32'(bus.rdata),  32'h0);
        rst = 1'b0;
        cycle();
        chk("first_gnt", 32'(obs_gnt), 32'h1);
        set_req(1, 0, 0, 0, 0);

        // write then read back from the other requester
        set_req(0, 1, 1, 3, 'hA5);
        cycle();
        set_req(1, 1, 0, 3, 0);
        cycle();
        chk("wr_rd_rvalid", 32'(bus.rvalid), 32'h2);
        chk("wr_rd_data",   32'(bus.rdata),  32'hA5);

        // preload and round-robin reads
        set_req(0, 1, 1, 1, 'h11);
        cycle();
        set_req(1, 1, 1, 2, 'h22);
        cycle();
        for (int k = 0; k < 6; k++) begin
            if (!bus.req[0]) set_req(0, 1, 0, 1, 0);
            if (!bus.req[1]) set_req(1, 1, 0, 2, 0);
            cycle();
            chk("rr_gnt",  32'(obs_gnt),   (k % 2) ? 32'h2 : 32'h1);
            chk("rr_data", 32'(bus.rdata), (k % 2) ? 32'h22 : 32'h11);
        end
        bus.req = '0;

        // read/write collision with prio at 1
        set_req(0, 1, 0, 0, 0);
        cycle();
        set_req(0, 1, 1, 5, 'h3C);
        set_req(1, 1, 0, 5, 0);
        cycle();
        chk("coll_gnt", 32'(obs_gnt),   32'h2);
        chk("coll_old", 32'(bus.rdata), 32'h00);
        cycle();
        chk("coll_wgnt", 32'(obs_gnt), 32'h1);
        set_req(1, 1, 0, 5, 0);
        cycle();
        chk("coll_new", 32'(bus.rdata), 32'h3C);

        // read, write, read back to back
        set_req(0, 1, 1, 0, 'h77);
        cycle();
        set_req(1, 1, 0, 0, 0);
        cycle();
        set_req(0, 1, 1, 7, 'h99);
        chk("b2b_hold", 32'(bus.rdata), 32'h77);
        cycle();
        set_req(1, 1, 0, 7, 0);
        cycle();
        chk("b2b_rd2", 32'(bus.rdata), 32'h99);

        // reset right after a read grant
        set_req(0, 1, 0, 2, 0);
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("mrst_rvalid", 32'(bus.rvalid), 32'h0);
        set_req(0, 1, 0, 1, 0);
        set_req(1, 1, 0, 2, 0);
        cycle();
        chk("mrst_prio", 32'(obs_gnt), 32'h1);
        bus.req = '0;

        // random traffic, small address range for frequent collisions
        for (int c = 0; c < 500; c++) begin
            rst = ($urandom_range(0, 59) == 0);
            for (int i = 0; i < NR; i++) begin
                if (!bus.req[i]) begin
                    if ($urandom_range(0, 2) != 0)
                        set_req(i, 1, 1'($urandom_range(0, 1)),
                                int'($urandom_range(0, 3)),
                                int'($urandom_range(0, 255)));
                end else if ($urandom_range(0, 15) == 0) begin
                    bus.req[i] = 1'b0;
                end
            end
            cycle();
        end
        rst = 1'b0;
        bus.req = '0;
        cycle();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Round-robin arbiter that shares one single-port synchronous RAM (write-or-read per cycle, registered read data, `dout` updated only on non-write cycles) among `NUM_REQ` requesters. Each cycle it grants at most one request, drives the RAM port from the winner, and returns read data one cycle later with a per-requester valid strobe. It sits directly in front of the RAM instance; requesters never touch the RAM port themselves.

## Interface
Parameters:
- `DATA_WIDTH`, 8, RAM word width
- `ADDR_WIDTH`, 4, RAM address width (depth = 2^ADDR_WIDTH)
- `NUM_REQ`, 2, number of requesters (2..8)

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req`  in  NUM_REQ  request per requester
- `req_we`  in  NUM_REQ  1 = write, 0 = read, per requester
- `req_addr`  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- `req_din`  in  NUM_REQ*DATA_WIDTH  packed write data, same packing
- `gnt`  out  NUM_REQ  one-hot (or zero) grant, combinational, same cycle as accepted request
- `rvalid`  out  NUM_REQ  one-hot read-data strobe, registered
- `rdata`  out  DATA_WIDTH  shared read data, meaningful only with `rvalid`
- `ram_we`  out  1  RAM write enable
- `ram_addr`  out  ADDR_WIDTH  RAM address
- `ram_din`  out  DATA_WIDTH  RAM write data
- `ram_dout`  in  DATA_WIDTH  RAM registered read data

## Operation
- Requester rule: hold `req`, `req_we`, `req_addr`, `req_din` stable until `gnt[i]` is seen high; the transfer completes on that clock edge. Deasserting before grant is allowed (request withdrawn).
- Arbitration: registered pointer `prio` (0..NUM_REQ-1). Winner = first asserted `req[i]` scanning i = prio, prio+1, ... with wrap-around modulo NUM_REQ.
- On a grant to i: `prio` <= (i+1) mod NUM_REQ at the clock edge. No grant: `prio` unchanged.
- RAM drive: granted requester's `req_we`/`req_addr`/`req_din` pass combinationally to `ram_we`/`ram_addr`/`ram_din`. No grant: `ram_we`=0, `ram_addr`=0, `ram_din`=0.
- Read tracking: registered `rd_pend` (1 bit) and `rd_id` (winner index). Set on a granted read, cleared otherwise.
- `rvalid[i]` = `rd_pend` and `rd_id`==i; `rdata` = `ram_dout` when `rd_pend`, else 0.
- Writes produce no response; `gnt` is the completion.
- Throughput: one access per cycle, back-to-back reads and writes from any mix of requesters, no bubbles.

## Timing
- Reset (`rst` high at a rising edge): `prio`=0, `rd_pend`=0. While `rst` is high, `gnt`=0, `ram_we`=0, `ram_addr`=0, `ram_din`=0, regardless of `req`. After the edge: `rvalid`=0, `rdata`=0.
- Reset mid-operation: a read granted in the cycle before reset has its response dropped (`rvalid` stays 0). Requesters must reissue.
- Read latency: grant in cycle N -> `rvalid[i]`=1 and `rdata` = mem[addr] in cycle N+1, for exactly one cycle.
- Write latency: granted in cycle N, memory updated at the end of N. A read of the same address granted in N+1 returns the new data in N+2.
- Same-cycle contention between a read and a write to one address: only one is granted. Arbitration order decides whether the read sees old or new data.
- Write in cycle N+1 after a read grant in N: `rdata` in N+1 is still valid, because RAM `dout` is updated at the end of N and held during write cycles.
- Single requester continuously asserting: granted every cycle, whatever the `prio` value.
- Fairness: with all requesters asserting, each is granted exactly once every NUM_REQ cycles.

## Test plan
- Reset: assert `rst` with `req`=2'b11 -> `gnt`=0, `ram_we`=0, `rvalid`=0, `rdata`=0. First grant after reset goes to requester 0.
- Write then read-back: req0 writes 0xA5 to addr 3 in cycle 1; req1 reads addr 3 in cycle 2 -> `rvalid`=2'b10 and `rdata`=0xA5 in cycle 3.
- Round-robin: both requesters hold read requests for 6 cycles, addrs 1/2 preloaded with 0x11/0x22 -> `gnt` alternates 01,10,01,..., and `rdata` alternates 0x11,0x22 with matching `rvalid`.
- Read/write collision: prio=1, req0 writes 0x3C to addr 5 (old 0x00) and req1 reads addr 5 in the same cycle -> req1 is granted first and gets 0x00. Then req0 is granted; a re-read returns 0x3C.
- Back-to-back mix: read addr 0 (0x77), then a write, then a read on consecutive cycles -> `rdata`=0x77 held valid in the write cycle. No lost or duplicated `rvalid`.
- Reset mid-read: read of addr 2 granted, `rst` asserted in the next cycle -> no `rvalid`, and `prio`=0 afterwards.
